// File: rtl/otp_rd_arb_pkg.sv
// otp_arb_pkg: shared definitions for the OTP read-port arbiter.
//   state_t            arbiter FSM encoding (ST_IDLE, ST_WAIT)
//   REQ_IF / REQ_LS    requester IDs, also the bit positions in req/gnt vectors
//   OTP_WORDS_DEFAULT  number of implemented OTP words
package otp_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam int unsigned REQ_IF = 0;
  localparam int unsigned REQ_LS = 1;

  localparam int unsigned OTP_WORDS_DEFAULT = 51;

endpackage

// File: rtl/otp_rd_arb_if.sv
// otp_rd_arb_if: requester-side bundle of the OTP read arbiter.
//   IF (fetch) and LS (load/store) each have req/addr held until gnt,
//   and receive a one-cycle rvalid pulse with rdata. rerr qualifies
//   whichever rvalid is high.
//   master: requester side (drives req/addr)
//   slave : arbiter side (drives gnt/rvalid/rdata/rerr)
interface otp_rd_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          ls_req;
  logic [AW-1:0] ls_addr;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [DW-1:0] ls_rdata;

  logic          rerr;

  modport master (
    output if_req, if_addr, ls_req, ls_addr,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, rerr
  );

  modport slave (
    input  if_req, if_addr, ls_req, ls_addr,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, rerr
  );
endinterface

// File: rtl/otp_rd_arb_rr_arb2.sv
// otp_rr_arb2: 2-way round-robin arbiter.
//   clk, rst  clock, synchronous active-high reset
//   req       request vector, bit REQ_IF / REQ_LS
//   advance   a grant is being taken this cycle; updates the pointer
//   gnt       combinational grant, one-hot or zero
//   last_reg  ID of the most recently granted requester (resets to LS,
//             so IF wins the first contention)
module otp_rr_arb2
  import otp_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       last_reg
);

  always_comb begin
    gnt = 2'b00;
    if (req[REQ_IF] && (!req[REQ_LS] || last_reg == 1'(REQ_LS))) begin
      gnt[REQ_IF] = 1'b1;
    end else if (req[REQ_LS]) begin
      gnt[REQ_LS] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg <= 1'(REQ_LS);
    end else if (advance && (gnt != 2'b00)) begin
      last_reg <= gnt[REQ_LS];
    end
  end

endmodule

// File: rtl/otp_rd_arb.sv
// otp_rd_arb: shares the combinational OTP read port between fetch (IF)
// and load/store (LS). The winner's address is latched onto otp_pa and
// held for cfg_wait extra cycles; the response word and error status are
// then registered and returned with a one-cycle rvalid pulse.
//   clk, rst      clock, synchronous active-high reset
//   cfg_wait      extra wait states, sampled at grant
//   bus           requester handshakes (otp_rd_arb_if.slave)
//   otp_pa        byte address to OTP (holds last address when idle)
//   otp_pdataout  OTP combinational read data
//   busy          high while an access is in flight (WAIT)
module otp_rd_arb
  import otp_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int OTP_WORDS = OTP_WORDS_DEFAULT,
  parameter int WW        = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [WW-1:0] cfg_wait,
  otp_rd_arb_if.slave   bus,
  output logic [AW-1:0] otp_pa,
  input  logic [DW-1:0] otp_pdataout,
  output logic          busy
);

  localparam logic [AW-3:0] WORD_LIMIT = (AW-2)'(OTP_WORDS);

  state_t        state_reg, state_next;
  logic [WW-1:0] cnt_reg;
  logic [AW-1:0] pa_reg;
  logic          rerr_reg;
  logic [1:0]    rvalid_reg;
  logic [1:0]    req_vec, gnt_vec, cap_sel;
  logic          last_reg;
  logic          grant, capture, acc_err;
  logic [AW-1:0] gnt_addr;

  // Requests are only visible to the arbiter in IDLE and outside reset,
  // so gnt can never assert during WAIT or for an access reset would drop.
  assign req_vec = (state_reg == ST_IDLE && !rst) ? {bus.ls_req, bus.if_req} : 2'b00;

  otp_rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_vec),
    .advance  (grant),
    .gnt      (gnt_vec),
    .last_reg (last_reg)
  );

  assign grant    = (gnt_vec != 2'b00);
  assign gnt_addr = gnt_vec[REQ_LS] ? bus.ls_addr : bus.if_addr;

  // The round-robin pointer only moves on a grant, so during WAIT it
  // names the owner of the access in flight.
  assign cap_sel  = capture ? (last_reg ? 2'b10 : 2'b01) : 2'b00;
  assign acc_err  = (pa_reg[1:0] != 2'b00) || (pa_reg[AW-1:2] >= WORD_LIMIT);

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    case (state_reg)
      ST_IDLE: if (grant) state_next = ST_WAIT;
      ST_WAIT: begin
        if (cnt_reg == '0) begin
          capture    = 1'b1;
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      pa_reg     <= '0;
      rerr_reg   <= 1'b0;
      rvalid_reg <= 2'b00;
    end else begin
      state_reg  <= state_next;
      rvalid_reg <= cap_sel;
      if (grant) begin
        cnt_reg <= cfg_wait;
        pa_reg  <= gnt_addr;
      end else if (state_reg == ST_WAIT && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
      if (capture) rerr_reg <= acc_err;
    end
  end

  // One response register per requester; the non-owner keeps its value.
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    logic [DW-1:0] rdata_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_reg <= '0;
      end else if (cap_sel[gi]) begin
        rdata_reg <= acc_err ? '0 : otp_pdataout;
      end
    end
  end

  assign otp_pa        = pa_reg;
  assign busy          = (state_reg == ST_WAIT);
  assign bus.if_gnt    = gnt_vec[REQ_IF];
  assign bus.ls_gnt    = gnt_vec[REQ_LS];
  assign bus.if_rvalid = rvalid_reg[REQ_IF];
  assign bus.ls_rvalid = rvalid_reg[REQ_LS];
  assign bus.if_rdata  = g_resp[0].rdata_reg;   // index 0 = REQ_IF
  assign bus.ls_rdata  = g_resp[1].rdata_reg;   // index 1 = REQ_LS
  assign bus.rerr      = rerr_reg;

endmodule

// File: doc/otp_rd_arb.md
Name: otp_rd_arb

Overview:
- Shares the single combinational OTP read port between two requesters: instruction fetch (IF) and load/store data reads (LS).
- Latches the granted address, holds it on the OTP address bus for a programmable number of wait states, then returns a registered data word and status to the winning requester.
- Sits between the core's fetch/LSU and the OTP instruction store.

Parameters:
- AW, 32, address width (byte address).
- DW, 32, data width.
- OTP_WORDS, 51, number of implemented OTP words; a word index at or above this is out of range.
- WW, 4, width of the wait-state count.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_wait  in  WW  extra wait states per access; sampled at grant.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  AW  fetch byte address.
- if_gnt  out  1  fetch request accepted this cycle (combinational).
- if_rvalid  out  1  one-cycle pulse: fetch data valid.
- if_rdata  out  DW  fetch data.
- ls_req  in  1  data read request; held with ls_addr until ls_gnt.
- ls_addr  in  AW  data byte address.
- ls_gnt  out  1  data request accepted this cycle (combinational).
- ls_rvalid  out  1  one-cycle pulse: data valid.
- ls_rdata  out  DW  data word.
- rerr  out  1  qualifies whichever rvalid is high: access was misaligned or out of range.
- otp_pa  out  AW  byte address to OTP.
- otp_pdataout  in  DW  OTP combinational read data.
- busy  out  1  high in the WAIT state.

Behaviour:
- Reset: one clock, synchronous, active-high. The following outputs reset to 0:
  - if_rvalid, ls_rvalid, rerr, if_rdata, ls_rdata, otp_pa, busy.
  - The round-robin pointer (last-grant bit) resets to LS, so IF wins the first contention.
  - The FSM resets to IDLE.
- FSM states: IDLE and WAIT.
- IDLE:
  - If any request is present, assert exactly one gnt combinationally.
  - Latch the requester ID, address and cnt <= cfg_wait, then go to WAIT.
  - If neither request is present, stay in IDLE.
- Arbitration:
  - Only one request: grant it.
  - Both requesting: grant the requester that is not the last-granted one (2-way round robin).
  - The pointer updates only on a grant.
- WAIT:
  - otp_pa = latched address; busy = 1.
  - While cnt != 0: cnt decrements each cycle.
  - When cnt == 0: capture the response into the owner's rdata register, pulse the owner's rvalid in the next cycle, and return to IDLE.
  - Capture rule: rdata = otp_pdataout, rerr = 0, except when addr[1:0] != 0 or addr[AW-1:2] >= OTP_WORDS. In that case rdata = 0 and rerr = 1.
- Latency:
  - Grant in cycle t means rvalid in cycle t+cfg_wait+2.
  - Throughput is one access per cfg_wait+2 cycles.
  - A new grant may occur in the same cycle rvalid is high, because the FSM is already back in IDLE.
- rdata persistence: the non-owner's rdata register is unchanged. rdata holds its value after rvalid drops.
- gnt is never asserted in WAIT. Requests arriving during WAIT wait for IDLE.
- Live inputs: cfg_wait changes during WAIT do not affect the access in flight. Requester addr/req changes after gnt are ignored.
- Reset mid-access: the FSM returns to IDLE and the access is dropped. No rvalid pulse is issued, either in the reset cycle or after it.
- Counter: cnt is WW bits and never wraps. cfg_wait = 2^WW-1 gives the maximum latency of 2^WW+1 cycles.
- Idle bus: otp_pa holds the last latched address while in IDLE.

Decomposition:
- Package otp_arb_pkg holds:
  - The state encoding (ST_IDLE, ST_WAIT).
  - Requester IDs (REQ_IF = 0, REQ_LS = 1).
  - The default OTP_WORDS constant.
- Sub-module otp_rr_arb2: a 2-way round-robin arbiter.
  - Inputs: req[1:0], advance.
  - Outputs: gnt[1:0] (one-hot or zero), last-grant pointer register.
  - All sequencing, latching and error checking stay in otp_rd_arb.

Test Plan:
- Single fetch: cfg_wait=0; IF req addr 0x8 at t with mem[2]=0xDEADBEEF. Expect if_gnt@t, otp_pa=0x8@t+1, if_rvalid@t+2 with if_rdata=0xDEADBEEF and rerr=0; ls_rvalid stays 0.
- Contention fairness: cfg_wait=1; IF and LS both request continuously from reset. Expect grant order IF, LS, IF, LS, with each rvalid at grant+3 and grants spaced 3 cycles apart.
- Wait states: cfg_wait=5; LS reads 0xC. Expect busy high for 6 cycles and ls_rvalid@t+7; changing cfg_wait to 0 at t+2 does not shorten this access.
- Errors: LS reads 0x6, then 0xCC (word index 51). Expect both responses with ls_rdata=0 and rerr=1; a following read of 0xC8 (word 50) returns mem[50] with rerr=0.
- Reset mid-access: cfg_wait=3; grant IF at t, rst high at t+2. Expect no if_rvalid at any cycle, FSM in IDLE at t+3, busy=0 at t+3, and a fresh request granted at t+3 when rst is low.
- Back-to-back: cfg_wait=0; IF requests continuously with addresses 0x0, 0x4, 0x8. Expect grants at t, t+2, t+4 and rvalid at t+2, t+4, t+6 with the matching data, each grant coincident with the previous rvalid.
